accum_step_decoder: RTL and testbench

- Inverse (receive/decode end) of the counter-accumulator chain, where the accumulator integrates a step that grows by a fixed increment every cycle.
- Consumes a stream of accumulated WIDTH-bit samples over a valid/ready handshake.
- Recovers each per-sample step by differencing (cur - prev, modulo 2^WIDTH).
- Checks the recovered steps against the expected arithmetic progression BASE_STEP, BASE_STEP+STEP_INC, ... and reports mismatches plus lock status.

---
 rtl/accum_step_decoder.sv | 127 ++++++++++++
 tb/tb_accum_step_decoder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_step_decoder.sv
// accum_step_decoder: receive-side inverse of the counter-accumulator chain.
// Differences consecutive accumulated samples to recover the per-sample step,
// checks it against the progression BASE_STEP, BASE_STEP+STEP_INC, ... and
// reports mismatches, a saturating error count and lock status.
// Optional build macro ACCUM_DEC_RESYNC_EN: on a mismatch, re-seed the
// expected step from the observed delta instead of staying on the ideal
// progression.
module accum_step_decoder #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] BASE_STEP = 1,
    parameter logic [WIDTH-1:0] STEP_INC  = 2,
    parameter int               ERR_CNT_W = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_delta,
    output logic                 out_err,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic {S_EMPTY, S_RUN} state_t;

    state_t state, state_nxt;

    // Tracking state for the incoming stream.
    logic [WIDTH-1:0]     prev_p0;
    logic [WIDTH-1:0]     expected_p0;
    logic [1:0]           match_run_p0;

    // Output register stage.
    logic                 vld_p1;
    logic [WIDTH-1:0]     delta_p1;
    logic                 err_p1;
    logic                 locked_p1;
    logic [ERR_CNT_W-1:0] err_cnt_p1;

    logic                 xfer;
    logic [WIDTH-1:0]     delta_c;
    logic                 mismatch_c;
    logic [1:0]           run_nxt;
    logic [WIDTH-1:0]     exp_nxt;

    function automatic logic [1:0] sat_run(input logic [1:0] v);
        return (v == 2'd2) ? 2'd2 : v + 2'd1;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_err(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Single output register: accept whenever it is empty or being drained.
    assign in_ready = !vld_p1 || out_ready;
    assign xfer     = in_valid && in_ready;

    assign delta_c    = in_data - prev_p0;
    assign mismatch_c = (delta_c != expected_p0);
    assign run_nxt    = mismatch_c ? 2'd0 : sat_run(match_run_p0);
`ifdef ACCUM_DEC_RESYNC_EN
    assign exp_nxt    = mismatch_c ? delta_c + STEP_INC : expected_p0 + STEP_INC;
`else
    assign exp_nxt    = expected_p0 + STEP_INC;
`endif

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_EMPTY;
        else        state <= state_nxt;
    end

    // Next state: first accepted sample primes prev, clear restarts.
    always_comb begin
        state_nxt = state;
        if (clear)     state_nxt = S_EMPTY;
        else if (xfer) state_nxt = S_RUN;
    end

    // Differencing, progression check and output register update.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prev_p0      <= '0;
            expected_p0  <= BASE_STEP;
            match_run_p0 <= 2'd0;
            vld_p1       <= 1'b0;
            delta_p1     <= '0;
            err_p1       <= 1'b0;
            locked_p1    <= 1'b0;
            err_cnt_p1   <= '0;
        end else if (clear) begin
            prev_p0      <= '0;
            expected_p0  <= BASE_STEP;
            match_run_p0 <= 2'd0;
            vld_p1       <= 1'b0;
            delta_p1     <= '0;
            err_p1       <= 1'b0;
            locked_p1    <= 1'b0;
            err_cnt_p1   <= '0;
        end else if (xfer && state == S_EMPTY) begin
            prev_p0 <= in_data;
            vld_p1  <= 1'b0;
        end else if (xfer) begin
            prev_p0      <= in_data;
            expected_p0  <= exp_nxt;
            match_run_p0 <= run_nxt;
            vld_p1       <= 1'b1;
            delta_p1     <= delta_c;
            err_p1       <= mismatch_c;
            locked_p1    <= (run_nxt == 2'd2);
            if (mismatch_c) err_cnt_p1 <= sat_err(err_cnt_p1);
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_delta = delta_p1;
    assign out_err   = err_p1;
    assign locked    = locked_p1;
    assign err_count = err_cnt_p1;

endmodule

// File: tb/tb_accum_step_decoder.sv
// Testbench for accum_step_decoder: table-driven sample streams with a
// scoreboard queue, plus hand-written backpressure, clear and reset sequences.
module tb_accum_step_decoder;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_delta;
    logic        out_err;
    logic        locked;
    logic [15:0] err_count;

    accum_step_decoder dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_delta (out_delta),
        .out_err   (out_err),
        .locked    (locked),
        .err_count (err_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] delta;
        bit          err;
        bit          lock;
        logic [15:0] ecnt;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        bit          clr;
        bit          has_out;
        logic [31:0] delta;
        bit          err;
        bit          lock;
        logic [15:0] ecnt;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    exp_t mon_e;
    exp_t none_e;
    vec_t vecs[13];

    function automatic exp_t mk(input logic [31:0] d, input bit er, input bit lk,
                                input logic [15:0] ec);
        exp_t e;
        e.delta = d; e.err = er; e.lock = lk; e.ecnt = ec;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Output monitor: compares every delivered output against the scoreboard.
    always @(negedge CLK) begin
        if (RST_N === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: actual delta=%0h required=none", out_delta);
            end else begin
                mon_e = sb.pop_front();
                check("out_delta", out_delta, mon_e.delta);
                check("out_err",   {31'b0, out_err}, {31'b0, mon_e.err});
                check("locked",    {31'b0, locked},  {31'b0, mon_e.lock});
                check("err_count", {16'b0, err_count}, {16'b0, mon_e.ecnt});
            end
        end
    end

    task automatic send(input logic [31:0] d, input bit has_out, input exp_t e);
        int n;
        bit ok;
        in_valid = 1'b1;
        in_data  = d;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge CLK);
            if (in_ready === 1'b1) ok = 1'b1;
            else n++;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: actual in_ready=0 required=1 data=%0h", d);
        end else if (has_out) begin
            sb.push_back(e);
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge CLK);
            #2;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    task automatic do_clear(input bit with_valid, input logic [31:0] d);
        clear    = 1'b1;
        in_valid = with_valid;
        in_data  = d;
        @(posedge CLK);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear_out_valid", {31'b0, out_valid}, 0);
        check("clear_err_count", {16'b0, err_count}, 0);
        check("clear_locked",    {31'b0, locked}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST_N     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        none_e    = mk(32'h0, 1'b0, 1'b0, 16'h0);

        // nominal stream 0,1,4,9,16
        vecs[0]  = '{32'h0000_0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{32'h0000_0001, 1'b0, 1'b1, 32'd1, 1'b0, 1'b0, 16'd0};
        vecs[2]  = '{32'h0000_0004, 1'b0, 1'b1, 32'd3, 1'b0, 1'b1, 16'd0};
        vecs[3]  = '{32'h0000_0009, 1'b0, 1'b1, 32'd5, 1'b0, 1'b1, 16'd0};
        vecs[4]  = '{32'h0000_0010, 1'b0, 1'b1, 32'd7, 1'b0, 1'b1, 16'd0};
        // wrap-around stream
        vecs[5]  = '{32'hFFFF_FFFE, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 16'd0};
        vecs[6]  = '{32'hFFFF_FFFF, 1'b0, 1'b1, 32'd1, 1'b0, 1'b0, 16'd0};
        vecs[7]  = '{32'h0000_0002, 1'b0, 1'b1, 32'd3, 1'b0, 1'b1, 16'd0};
        // mismatch stream 0,1,4,10,17
        vecs[8]  = '{32'h0000_0000, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 16'd0};
        vecs[9]  = '{32'h0000_0001, 1'b0, 1'b1, 32'd1, 1'b0, 1'b0, 16'd0};
        vecs[10] = '{32'h0000_0004, 1'b0, 1'b1, 32'd3, 1'b0, 1'b1, 16'd0};
        vecs[11] = '{32'h0000_000A, 1'b0, 1'b1, 32'd6, 1'b1, 1'b0, 16'd1};
`ifdef ACCUM_DEC_RESYNC_EN
        vecs[12] = '{32'h0000_0011, 1'b0, 1'b1, 32'd7, 1'b1, 1'b0, 16'd2};
`else
        vecs[12] = '{32'h0000_0011, 1'b0, 1'b1, 32'd7, 1'b0, 1'b0, 16'd1};
`endif

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_out_delta", out_delta, 0);
        check("rst_out_err",   {31'b0, out_err}, 0);
        check("rst_locked",    {31'b0, locked}, 0);
        check("rst_err_count", {16'b0, err_count}, 0);
        check("rst_in_ready",  {31'b0, in_ready}, 1);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // Table-driven streams
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].clr) begin
                drain();
                do_clear(1'b0, 32'h0);
            end
            send(vecs[i].data, vecs[i].has_out,
                 mk(vecs[i].delta, vecs[i].err, vecs[i].lock, vecs[i].ecnt));
        end
        drain();
`ifdef ACCUM_DEC_RESYNC_EN
        check("errcnt_before_clear", {16'b0, err_count}, 2);
`else
        check("errcnt_before_clear", {16'b0, err_count}, 1);
`endif

        // clear together with a valid transfer: sample dropped, next only primes
        do_clear(1'b1, 32'h0000_0099);
        send(32'd5, 1'b0, none_e);
        send(32'd6, 1'b1, mk(32'd1, 1'b0, 1'b0, 16'd0));
        drain();

        // Backpressure: stall 3 cycles while delta 3 is pending
        do_clear(1'b0, 32'h0);
        send(32'd0, 1'b0, none_e);
        send(32'd1, 1'b1, mk(32'd1, 1'b0, 1'b0, 16'd0));
        send(32'd4, 1'b1, mk(32'd3, 1'b0, 1'b1, 16'd0));
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'd9;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("stall_in_ready",  {31'b0, in_ready}, 0);
            check("stall_out_valid", {31'b0, out_valid}, 1);
            check("stall_out_delta", out_delta, 3);
            if (i < 2) @(posedge CLK);
        end
        @(posedge CLK);
        #1;
        out_ready = 1'b1;
        send(32'd9,  1'b1, mk(32'd5, 1'b0, 1'b1, 16'd0));
        send(32'd16, 1'b1, mk(32'd7, 1'b0, 1'b1, 16'd0));
        drain();

        // Asynchronous reset mid-stream
        do_clear(1'b0, 32'h0);
        send(32'd0, 1'b0, none_e);
        send(32'd1, 1'b1, mk(32'd1, 1'b0, 1'b0, 16'd0));
        RST_N = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'b0, out_valid}, 0);
        check("mid_rst_out_delta", out_delta, 0);
        check("mid_rst_locked",    {31'b0, locked}, 0);
        check("mid_rst_err_count", {16'b0, err_count}, 0);
        sb.delete();
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        send(32'd20, 1'b0, none_e);
        send(32'd21, 1'b1, mk(32'd1, 1'b0, 1'b0, 16'd0));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
